// File: rtl/cvp_vector_lsu.sv
// cvp_vector_lsu: strided vector load/store sequencer with wait-state handshake.
// Reads are pipelined one deep; the returned word lands in the lane recorded at accept time.
module cvp_vector_lsu #(
    parameter int LANES = 16,
    parameter int EW    = 16,
    parameter int AW    = 16,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic                Clk1,
    input  logic                Reset,
    input  logic                start,
    input  logic                is_store,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW-1:0]       stride,
    input  logic [CW-1:0]       count,
    input  logic [LANES*EW-1:0] store_data,
    input  logic                mem_wait,
    input  logic [EW-1:0]       DataIn,
    output logic [AW-1:0]       Addr,
    output logic                RD,
    output logic                WR,
    output logic                V,
    output logic [EW-1:0]       dataOut,
    output logic                busy,
    output logic                done,
    output logic [LANES*EW-1:0] load_data
);
    typedef enum logic [2:0] {IDLE, LOAD, LDRAIN, STORE, DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d, stride_q;
    logic [CW-1:0]       idx_q, idx_d, n_q, plidx_q, n_in;
    logic [LANES*EW-1:0] sdata_q, ld_q;
    logic                pv_q, pv_d, last, take;

    assign n_in = (count > CW'(LANES)) ? CW'(LANES) : count;
    assign last = idx_q == n_q - CW'(1);
    assign take = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pv_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = base_addr;
                idx_d   = '0;
                state_d = (n_in == '0) ? DONE : is_store ? STORE : LOAD;
            end
            LOAD, STORE: if (!mem_wait) begin
                addr_d = addr_q + stride_q;
                idx_d  = idx_q + CW'(1);
                pv_d   = state_q == LOAD;
                if (last) state_d = (state_q == LOAD) ? LDRAIN : DONE;
            end
            LDRAIN:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign RD        = state_q == LOAD;
    assign WR        = state_q == STORE;
    assign V         = RD | WR;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign Addr      = V ? addr_q : '0;
    assign dataOut   = WR ? sdata_q[int'(idx_q)*EW +: EW] : '0;
    assign load_data = ld_q;

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            idx_q    <= '0;
            n_q      <= '0;
            plidx_q  <= '0;
            pv_q     <= 1'b0;
            sdata_q  <= '0;
            ld_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pv_q    <= pv_d;
            plidx_q <= idx_q;
            if (take) begin
                stride_q <= stride;
                n_q      <= n_in;
                sdata_q  <= store_data;
            end
            // a zero-length load leaves the previous result in place
            if (take && !is_store && n_in != '0) ld_q <= '0;
            else if (pv_q) ld_q[int'(plidx_q)*EW +: EW] <= DataIn;
        end
    end
endmodule

// File: tb/tb_cvp_vector_lsu.sv
// tb_cvp_vector_lsu: table-driven directed checks plus reset and ignored-start sequences.
module tb_cvp_vector_lsu;
    logic          Clk1 = 1'b0, Reset = 1'b1, start = 1'b0, is_store = 1'b0, mem_wait = 1'b0;
    logic [15:0]   base_addr = '0, stride = '0, DataIn = '0;
    logic [4:0]    count = '0;
    logic [255:0]  store_data;
    logic [15:0]   Addr, dataOut;
    logic          RD, WR, V, busy, done;
    logic [255:0]  load_data;

    typedef struct {
        logic        st;
        logic [15:0] base;
        logic [15:0] strd;
        logic [4:0]  cnt;
        logic [63:0] wm;
        int          spur;
        int          exp_done;
    } vec_t;

    vec_t        tv [9];
    logic [15:0] exp_ld [16];
    int          checks = 0, errors = 0;

    cvp_vector_lsu dut (
        .Clk1(Clk1), .Reset(Reset), .start(start), .is_store(is_store),
        .base_addr(base_addr), .stride(stride), .count(count), .store_data(store_data),
        .mem_wait(mem_wait), .DataIn(DataIn), .Addr(Addr), .RD(RD), .WR(WR), .V(V),
        .dataOut(dataOut), .busy(busy), .done(done), .load_data(load_data)
    );

    always #5 Clk1 = ~Clk1;

    // memory returns word = address one cycle after an accepted read, garbage otherwise
    always @(posedge Clk1) DataIn <= (RD && !mem_wait) ? Addr : 16'hDEAD;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check_lanes(input string nm);
        for (int i = 0; i < 16; i++) check(nm, 32'(load_data[i*16 +: 16]), 32'(exp_ld[i]));
    endtask

    task automatic run(input vec_t v);
        int beats = 0, dc = 0;
        int n = (v.cnt > 5'd16) ? 16 : int'(v.cnt);
        @(negedge Clk1);
        start = 1'b1; is_store = v.st; base_addr = v.base; stride = v.strd; count = v.cnt; mem_wait = 1'b0;
        @(posedge Clk1);
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            @(negedge Clk1);
            start = (c == v.spur);
            if (c == v.spur) begin
                is_store = ~v.st; base_addr = 16'h7777; count = 5'd16;
            end
            mem_wait = (c < 64) ? v.wm[c] : 1'b0;
            if (RD | WR) begin
                check("dir", {30'd0, RD, WR}, v.st ? 32'd1 : 32'd2);
                check("addr", 32'(Addr), 32'(16'(v.base + 16'(beats) * v.strd)));
                if (WR) check("wdata", 32'(dataOut), 32'(16'hA000 + 16'(beats)));
                if (!mem_wait) beats++;
            end else begin
                check("idle_bus", {Addr, dataOut}, 32'd0);
            end
            if (done) dc = c;
        end
        start = 1'b0; mem_wait = 1'b0;
        check("done_cycle", dc, v.exp_done);
        check("beats", beats, n);
        if (!v.st && n > 0)
            for (int i = 0; i < 16; i++) exp_ld[i] = (i < n) ? 16'(v.base + 16'(i) * v.strd) : 16'h0;
        check_lanes("lane");
        @(negedge Clk1);
        check("post_done", {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            store_data[i*16 +: 16] = 16'hA000 + 16'(i);
            exp_ld[i] = 16'h0;
        end
        tv[0] = '{1'b0, 16'h0100, 16'h0001, 5'd16, 64'h0,  0, 18};
        tv[1] = '{1'b1, 16'h0200, 16'h0004, 5'd3,  64'h0,  2, 4};
        tv[2] = '{1'b0, 16'h0300, 16'h0001, 5'd4,  64'hC,  0, 8};
        tv[3] = '{1'b0, 16'h0900, 16'h0001, 5'd0,  64'h0,  0, 1};
        tv[4] = '{1'b0, 16'h0400, 16'h0002, 5'd31, 64'h0,  0, 18};
        tv[5] = '{1'b0, 16'hFFFE, 16'h0001, 5'd4,  64'h0,  0, 6};
        tv[6] = '{1'b0, 16'h0050, 16'hFFFF, 5'd5,  64'h0,  0, 7};
        tv[7] = '{1'b1, 16'h1000, 16'hFFFF, 5'd16, 64'h20, 0, 18};
        tv[8] = '{1'b1, 16'h0800, 16'h0001, 5'd0,  64'h0,  0, 1};

        repeat (2) @(negedge Clk1);
        check("rst_ctl", {27'd0, RD, WR, V, busy, done}, 32'd0);
        check("rst_bus", {Addr, dataOut}, 32'd0);
        check_lanes("rst_lane");
        Reset = 1'b0;

        for (int k = 0; k < 9; k++) run(tv[k]);

        // reset while the load is issuing element 5
        @(negedge Clk1);
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0500; stride = 16'h0001; count = 5'd10;
        @(posedge Clk1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk1);
            start = 1'b0;
        end
        check("mid_rd", {15'd0, RD, Addr}, {15'd0, 1'b1, 16'h0505});
        Reset = 1'b1;
        #1;
        check("rst_async_ctl", {29'd0, RD, busy, done}, 32'd0);
        check("rst_async_addr", 32'(Addr), 32'd0);
        for (int i = 0; i < 16; i++) exp_ld[i] = 16'h0;
        check_lanes("rst_async_lane");
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk1);
            if (c == 1) Reset = 1'b0;
            check("no_done", {31'd0, done}, 32'd0);
        end
        run(tv[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
